// File: rtl/hier_fanout_pkg.sv
// Shared types and defaults for the hierarchical fan-out/fan-in controller.
package hier_fanout_pkg;

  localparam int DEF_N_CHILD = 5;
  localparam int DEF_TAG_W   = 8;
  localparam int DEF_TO_W    = 8;
  localparam int DEF_TIMEOUT = 200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Aggregated response at the default geometry, for callers that use it.
  typedef struct packed {
    logic [DEF_TAG_W-1:0]   tag;
    logic [DEF_N_CHILD-1:0] done_mask;
    logic [DEF_N_CHILD-1:0] err_mask;
    logic                   timeout;
  } rsp_t;

endpackage

// File: rtl/hier_fanout_if.sv
// Command, child and response signals between a parent sequencer (master)
// and the fan-out controller (slave).
interface hier_fanout_if #(
  parameter int N_CHILD = 5,
  parameter int TAG_W   = 8
);
  logic               start_valid;
  logic               start_ready;
  logic [N_CHILD-1:0] start_mask;
  logic [TAG_W-1:0]   start_tag;
  logic [N_CHILD-1:0] child_go;
  logic [N_CHILD-1:0] child_done;
  logic [N_CHILD-1:0] child_err;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [TAG_W-1:0]   rsp_tag;
  logic [N_CHILD-1:0] rsp_done_mask;
  logic [N_CHILD-1:0] rsp_err_mask;
  logic               rsp_timeout;

  modport master (
    output start_valid, start_mask, start_tag, child_done, child_err, rsp_ready,
    input  start_ready, child_go, rsp_valid, rsp_tag, rsp_done_mask,
           rsp_err_mask, rsp_timeout
  );

  modport slave (
    input  start_valid, start_mask, start_tag, child_done, child_err, rsp_ready,
    output start_ready, child_go, rsp_valid, rsp_tag, rsp_done_mask,
           rsp_err_mask, rsp_timeout
  );
endinterface

// File: rtl/hier_fanout_timer.sv
// Saturating cycle timer: clear wins over enable, expire flags the last
// allowed cycle (count == TIMEOUT-1) and stays high while saturated.
module hier_fanout_timer
  import hier_fanout_pkg::*;
#(
  parameter int TO_W    = DEF_TO_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  // Count enabled cycles, holding at all-ones instead of wrapping.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + TO_W'(1);
    end
  end

  assign expire = (count >= LAST);
endmodule

// File: rtl/hier_fanout_ctrl.sv
// Broadcasts a tagged go to a subset of child slots, collects done/err
// completions under a timeout and returns one aggregated response.
module hier_fanout_ctrl
  import hier_fanout_pkg::*;
#(
  parameter int N_CHILD = DEF_N_CHILD,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int TO_W    = DEF_TO_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  hier_fanout_if.slave  bus,
  output logic          busy
);
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [N_CHILD-1:0] done_mask;
    logic [N_CHILD-1:0] err_mask;
    logic               timeout;
  } rsp_fields_t;

  state_t             state;
  logic [N_CHILD-1:0] mask_q;
  logic [TAG_W-1:0]   tag_q;
  logic [N_CHILD-1:0] done_q;
  logic [N_CHILD-1:0] err_q;
  logic [N_CHILD-1:0] go_q;
  logic               start_ready_q;
  logic               rsp_valid_q;
  rsp_fields_t        rsp_q;

  // First completions this cycle: masked children that have not finished yet.
  logic [N_CHILD-1:0] new_hits;
  logic [N_CHILD-1:0] done_nxt;
  logic [N_CHILD-1:0] err_nxt;
  logic [N_CHILD-1:0] pending;
  logic               expire;

  assign new_hits = bus.child_done & mask_q & ~done_q;
  assign done_nxt = done_q | new_hits;
  assign err_nxt  = err_q | (new_hits & bus.child_err);
  assign pending  = mask_q & ~done_nxt;

  hier_fanout_timer #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state == ST_DISPATCH),
    .enable((state == ST_WAIT) && (pending != '0)),
    .expire(expire)
  );

  // Command sequencer with registered handshake, go and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      mask_q        <= '0;
      tag_q         <= '0;
      done_q        <= '0;
      err_q         <= '0;
      go_q          <= '0;
      start_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_q         <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          start_ready_q <= 1'b1;
          if (start_ready_q && bus.start_valid) begin
            mask_q        <= bus.start_mask;
            tag_q         <= bus.start_tag;
            done_q        <= '0;
            err_q         <= '0;
            start_ready_q <= 1'b0;
            busy          <= 1'b1;
            if (bus.start_mask != '0) begin
              go_q  <= bus.start_mask;
              state <= ST_DISPATCH;
            end else begin
              // Empty selection completes at once with an empty response.
              rsp_valid_q <= 1'b1;
              rsp_q       <= '{tag: bus.start_tag, done_mask: '0, err_mask: '0, timeout: 1'b0};
              state       <= ST_RESP;
            end
          end
        end
        ST_DISPATCH: begin
          go_q  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          done_q <= done_nxt;
          err_q  <= err_nxt;
          // Completion in the expiry cycle wins: timeout only if work remains.
          if ((pending == '0) || expire) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= '{tag: tag_q, done_mask: done_nxt, err_mask: err_nxt,
                             timeout: (pending != '0)};
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_q         <= '0;
            busy          <= 1'b0;
            start_ready_q <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready   = start_ready_q;
  assign bus.child_go      = go_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_tag       = rsp_q.tag;
  assign bus.rsp_done_mask = rsp_q.done_mask;
  assign bus.rsp_err_mask  = rsp_q.err_mask;
  assign bus.rsp_timeout   = rsp_q.timeout;
endmodule

// File: tb/tb_hier_fanout_ctrl.sv
// Self-checking bench for hier_fanout_ctrl: directed scenarios plus random
// commands, each judged by a per-child completion-time model.
module tb_hier_fanout_ctrl;
  localparam int N   = 5;
  localparam int TW  = 8;
  localparam int TOW = 8;
  localparam int TO  = 10;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  hier_fanout_if #(.N_CHILD(N), .TAG_W(TW)) bus ();

  hier_fanout_ctrl #(
    .N_CHILD(N), .TAG_W(TW), .TO_W(TOW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-child plan: slot (cycles after accept) at which done is first driven,
  // and the err value presented with it.
  int          done_at [N];
  logic [N-1:0] err_bit;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.start_ready, bus.child_go, bus.rsp_valid, bus.rsp_tag,
                     bus.rsp_done_mask, bus.rsp_err_mask, bus.rsp_timeout, busy}), 64'(0));
  endtask

  task automatic set_never();
    for (int i = 0; i < N; i++) done_at[i] = NEVER;
    err_bit = '0;
  endtask

  // Planned done pulses plus noise the DUT must ignore: dispatch-cycle pulses,
  // repeats after completion, and anything on unselected children.
  task automatic drive_children(input int c, input logic [N-1:0] mask);
    logic [N-1:0] d, e;
    int unsigned r;
    for (int i = 0; i < N; i++) begin
      r = $urandom;
      if (mask[i]) begin
        d[i] = (c == done_at[i]) || ((c == 1) && r[0]) ||
               ((done_at[i] >= 2) && (c > done_at[i]) && r[0]);
        e[i] = (c == done_at[i]) ? err_bit[i] : r[1];
      end else begin
        d[i] = r[0];
        e[i] = r[1];
      end
    end
    bus.child_done = d;
    bus.child_err  = e;
  endtask

  task automatic run_cmd(input logic [N-1:0] mask, input logic [TW-1:0] tag, input int hold);
    logic [N-1:0] exp_done, exp_err;
    logic         exp_to;
    bit           complete;
    int           last, exp_c;

    exp_done = '0;
    exp_err  = '0;
    complete = 1'b1;
    last     = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        // WAIT starts at slot 2 and lasts at most TO cycles.
        if ((done_at[i] >= 2) && (done_at[i] <= TO + 1)) begin
          exp_done[i] = 1'b1;
          exp_err[i]  = err_bit[i];
          if (done_at[i] - 2 > last) last = done_at[i] - 2;
        end else begin
          complete = 1'b0;
        end
      end
    end
    exp_to = (mask != '0) && !complete;
    exp_c  = (mask == '0) ? 1 : (complete ? 3 + last : TO + 2);

    bus.start_valid = 1'b1;
    bus.start_mask  = mask;
    bus.start_tag   = tag;
    check("start_ready_idle", 64'(bus.start_ready), 64'(1));
    check("busy_idle", 64'(busy), 64'(0));
    next_slot();
    bus.start_valid = 1'b0;
    bus.start_mask  = N'($urandom);
    bus.start_tag   = TW'($urandom);

    for (int c = 1; c <= exp_c; c++) begin
      check("child_go", 64'(bus.child_go), 64'((c == 1) ? mask : '0));
      check("rsp_valid_timing", 64'(bus.rsp_valid), 64'(c == exp_c));
      if (c < exp_c) begin
        drive_children(c, mask);
        next_slot();
      end
    end

    check("rsp_fields", 64'({bus.rsp_tag, bus.rsp_done_mask, bus.rsp_err_mask, bus.rsp_timeout}),
          64'({tag, exp_done, exp_err, exp_to}));
    check("busy_resp", 64'(busy), 64'(1));

    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready  = 1'b0;
      bus.child_done = N'($urandom);
      bus.child_err  = N'($urandom);
      next_slot();
      check("rsp_hold", 64'({bus.rsp_valid, bus.start_ready, bus.rsp_tag, bus.rsp_done_mask,
                              bus.rsp_err_mask, bus.rsp_timeout}),
            64'({1'b1, 1'b0, tag, exp_done, exp_err, exp_to}));
    end

    bus.rsp_ready = 1'b1;
    next_slot();
    bus.rsp_ready  = 1'b0;
    bus.child_done = '0;
    bus.child_err  = '0;
    check("after_handshake", 64'({bus.rsp_valid, busy, bus.start_ready}), 64'(3'b001));
  endtask

  // Start an all-child command that never completes and reset it at slot s.
  task automatic reset_during(input int s);
    set_never();
    bus.start_valid = 1'b1;
    bus.start_mask  = '1;
    bus.start_tag   = 8'hA5;
    next_slot();
    bus.start_valid = 1'b0;
    for (int c = 1; c < s; c++) begin
      drive_children(c, '1);
      next_slot();
    end
    check("pre_reset_busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    #1 check_all_zero("rst_held");
    #3 rst = 1'b0;
    bus.child_done = '0;
    bus.child_err  = '0;
    check("ready_before_clk", 64'(bus.start_ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      next_slot();
      check("post_reset_idle", 64'({bus.start_ready, bus.rsp_valid, bus.child_go, busy}),
            64'({1'b1, 1'b0, 5'b0, 1'b0}));
    end
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.start_mask  = '0;
    bus.start_tag   = '0;
    bus.child_done  = '0;
    bus.child_err   = '0;
    bus.rsp_ready   = 1'b0;

    // Reset state.
    #12 check_all_zero("reset_state");
    #1 rst = 1'b0;
    check("ready_before_first_clk", 64'(bus.start_ready), 64'(0));
    next_slot();
    check("ready_after_first_clk", 64'(bus.start_ready), 64'(1));

    // Staggered completions on children 0, 2, 4.
    set_never();
    done_at[0] = 2; done_at[2] = 5; done_at[4] = 9;
    run_cmd(5'b10101, 8'h3C, 1);

    // Child 1 never completes: timeout after TO WAIT cycles.
    set_never();
    done_at[0] = 4;
    run_cmd(5'b00011, 8'h21, 0);

    // Child 3 completes with error; unselected children toggle freely.
    set_never();
    done_at[3] = 3; err_bit[3] = 1'b1;
    run_cmd(5'b01000, 8'h55, 2);

    // Empty mask: immediate response, held for 5 cycles.
    set_never();
    run_cmd(5'b00000, 8'h7F, 5);

    // Minimum latency: everything done in the first WAIT cycle.
    set_never();
    for (int i = 0; i < N; i++) done_at[i] = 2;
    err_bit = 5'b10010;
    run_cmd(5'b11111, 8'h01, 0);

    // Last done in the expiry cycle, then one cycle too late.
    set_never();
    done_at[1] = 3; done_at[2] = TO + 1;
    run_cmd(5'b00110, 8'h66, 1);
    set_never();
    done_at[1] = 3; done_at[2] = TO + 2;
    run_cmd(5'b00110, 8'h67, 1);

    // Reset mid-command (WAIT, then DISPATCH), then normal operation.
    reset_during(4);
    reset_during(1);
    set_never();
    done_at[0] = 2; done_at[2] = 5; done_at[4] = 9;
    run_cmd(5'b10101, 8'h3C, 0);

    // Random commands.
    for (int k = 0; k < 25; k++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++)
        done_at[i] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, TO + 3));
      err_bit = N'($urandom);
      run_cmd(m, TW'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
